// File: rtl/maze_pkg.sv
// Shared definitions for the maze icon mover: direction codes, per-axis step
// decode, FSM state type and default geometry/timing constants.
package maze_pkg;

  typedef enum logic [3:0] {
    DIR_STOP = 4'd0,
    DIR_N    = 4'd1,
    DIR_S    = 4'd2,
    DIR_E    = 4'd3,
    DIR_W    = 4'd4,
    DIR_NE   = 4'd5,
    DIR_SE   = 4'd6,
    DIR_SW   = 4'd7,
    DIR_NW   = 4'd8
  } dir_e;

  typedef enum logic [1:0] {
    AX_HOLD = 2'd0,
    AX_INC  = 2'd1,
    AX_DEC  = 2'd2
  } axis_step_e;

  typedef struct packed {
    axis_step_e dx;
    axis_step_e dy;
  } dir_delta_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mover_state_e;

  localparam int unsigned DEF_COORD_W     = 8;
  localparam int unsigned DEF_MIN_X       = 3;
  localparam int unsigned DEF_MAX_X       = 124;
  localparam int unsigned DEF_MIN_Y       = 3;
  localparam int unsigned DEF_MAX_Y       = 124;
  localparam int unsigned DEF_START_X     = 32;
  localparam int unsigned DEF_START_Y     = 32;
  localparam int unsigned DEF_TICK_W      = 28;
  localparam int unsigned DEF_TICK_PERIOD = 1048575;

  // North is Y+1 and east is X+1; codes 9-15 decode as no movement.
  function automatic dir_delta_t dir_decode(input logic [3:0] code);
    dir_delta_t d;
    d.dx = AX_HOLD;
    d.dy = AX_HOLD;
    case (code)
      DIR_N:   d.dy = AX_INC;
      DIR_S:   d.dy = AX_DEC;
      DIR_E:   d.dx = AX_INC;
      DIR_W:   d.dx = AX_DEC;
      DIR_NE:  begin d.dx = AX_INC; d.dy = AX_INC; end
      DIR_SE:  begin d.dx = AX_INC; d.dy = AX_DEC; end
      DIR_SW:  begin d.dx = AX_DEC; d.dy = AX_DEC; end
      DIR_NW:  begin d.dx = AX_DEC; d.dy = AX_INC; end
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic dir_is_move(input logic [3:0] code);
    return (code >= 4'd1) && (code <= 4'd8);
  endfunction

endpackage

// File: rtl/maze_icon_mover_if.sv
// Command/status bundle between the motor-control decoder, the maze icon mover
// and the display/map-lookup side.
interface maze_icon_mover_if #(
  parameter int COORD_W = 8
);
  // No valid/ready pair: dir, speed, walls and home are levels sampled on every
  // rising edge; moved and bumped are single-cycle strobes aligned with loc_x/loc_y.
  logic [3:0]         dir;
  logic [1:0]         speed;
  logic               wall_n;
  logic               wall_e;
  logic               wall_s;
  logic               wall_w;
  logic               home;
  logic [COORD_W-1:0] loc_x;
  logic [COORD_W-1:0] loc_y;
  logic               moved;
  logic               bumped;

  modport master (
    output dir, speed, wall_n, wall_e, wall_s, wall_w, home,
    input  loc_x, loc_y, moved, bumped
  );

  modport slave (
    input  dir, speed, wall_n, wall_e, wall_s, wall_w, home,
    output loc_x, loc_y, moved, bumped
  );
endinterface

// File: rtl/maze_icon_mover_step_timer.sv
// Step-rate counter: restarts on clear, holds at zero when idle and fires a
// tick every (TICK_PERIOD >> speed) edges while running.
module maze_icon_mover_step_timer #(
  parameter int          TICK_W      = 28,
  parameter int unsigned TICK_PERIOD = 1048575
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              run_i,
  input  logic [1:0]        speed_i,
  output logic              tick_o,
  output logic [TICK_W-1:0] count_o
);

  localparam logic [TICK_W-1:0] BASE_PERIOD = TICK_W'(TICK_PERIOD);

  logic [TICK_W-1:0] cnt_q;
  logic [TICK_W-1:0] cnt_d;
  logic [TICK_W-1:0] last_cnt;

  // Speed is re-read every edge; ">=" lets a shortened period fire right away
  // when the running count already passed the new terminal value.
  assign last_cnt = (BASE_PERIOD >> speed_i) - TICK_W'(1);

  always_comb begin
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (clear_i || !run_i) begin
      cnt_d = '0;
    end else if (cnt_q >= last_cnt) begin
      cnt_d  = '0;
      tick_o = 1'b1;
    end else begin
      cnt_d = cnt_q + TICK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/maze_icon_mover.sv
// Maze icon position tracker. Define MAZE_ICON_WRAP_EN to wrap at the X/Y
// bounds instead of refusing the step (walls always block).
module maze_icon_mover
  import maze_pkg::*;
#(
  parameter int          COORD_W     = DEF_COORD_W,
  parameter int unsigned MIN_X       = DEF_MIN_X,
  parameter int unsigned MAX_X       = DEF_MAX_X,
  parameter int unsigned MIN_Y       = DEF_MIN_Y,
  parameter int unsigned MAX_Y       = DEF_MAX_Y,
  parameter int unsigned START_X     = DEF_START_X,
  parameter int unsigned START_Y     = DEF_START_Y,
  parameter int          TICK_W      = DEF_TICK_W,
  parameter int unsigned TICK_PERIOD = DEF_TICK_PERIOD
) (
  input  logic               clk,
  input  logic               rst_n,
  maze_icon_mover_if.slave   bus,
  output mover_state_e       state_o,
  output logic [TICK_W-1:0]  count_o
);

`ifdef MAZE_ICON_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam logic [COORD_W-1:0] MIN_XC   = COORD_W'(MIN_X);
  localparam logic [COORD_W-1:0] MAX_XC   = COORD_W'(MAX_X);
  localparam logic [COORD_W-1:0] MIN_YC   = COORD_W'(MIN_Y);
  localparam logic [COORD_W-1:0] MAX_YC   = COORD_W'(MAX_Y);
  localparam logic [COORD_W-1:0] START_XC = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] START_YC = COORD_W'(START_Y);

  mover_state_e       state_q, state_d;
  logic [3:0]         dir_q;
  logic [COORD_W-1:0] loc_x_q, loc_x_d;
  logic [COORD_W-1:0] loc_y_q, loc_y_d;
  logic               moved_q, moved_d;
  logic               bumped_q, bumped_d;

  logic               dir_change;
  logic               tick;
  dir_delta_t         delta;
  logic               x_free, y_free;
  logic [COORD_W-1:0] next_x, next_y;

  assign dir_change = (bus.dir != dir_q);
  assign delta      = dir_decode(dir_q);

  always_comb begin
    state_d = dir_is_move(bus.dir) ? ST_RUN : ST_IDLE;
  end

  maze_icon_mover_step_timer #(
    .TICK_W      (TICK_W),
    .TICK_PERIOD (TICK_PERIOD)
  ) u_step_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (bus.home || dir_change),
    .run_i   (state_q == ST_RUN),
    .speed_i (bus.speed),
    .tick_o  (tick),
    .count_o (count_o)
  );

  // Bounds are compared before the add/subtract, so the arithmetic never wraps
  // on its own; only the explicit wrap path reloads the opposite bound.
  always_comb begin
    x_free = 1'b1;
    next_x = loc_x_q;
    case (delta.dx)
      AX_INC: begin
        x_free = !bus.wall_e && (WRAP_EN || (loc_x_q < MAX_XC));
        next_x = (loc_x_q >= MAX_XC) ? MIN_XC : loc_x_q + COORD_W'(1);
      end
      AX_DEC: begin
        x_free = !bus.wall_w && (WRAP_EN || (loc_x_q > MIN_XC));
        next_x = (loc_x_q <= MIN_XC) ? MAX_XC : loc_x_q - COORD_W'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    y_free = 1'b1;
    next_y = loc_y_q;
    case (delta.dy)
      AX_INC: begin
        y_free = !bus.wall_n && (WRAP_EN || (loc_y_q < MAX_YC));
        next_y = (loc_y_q >= MAX_YC) ? MIN_YC : loc_y_q + COORD_W'(1);
      end
      AX_DEC: begin
        y_free = !bus.wall_s && (WRAP_EN || (loc_y_q > MIN_YC));
        next_y = (loc_y_q <= MIN_YC) ? MAX_YC : loc_y_q - COORD_W'(1);
      end
      default: ;
    endcase
  end

  // Home beats the tick (the timer is cleared by home, so tick is already low);
  // a diagonal moves both axes or neither.
  always_comb begin
    loc_x_d  = loc_x_q;
    loc_y_d  = loc_y_q;
    moved_d  = 1'b0;
    bumped_d = 1'b0;
    if (bus.home) begin
      loc_x_d = START_XC;
      loc_y_d = START_YC;
      moved_d = (loc_x_q != START_XC) || (loc_y_q != START_YC);
    end else if (tick) begin
      if (x_free && y_free) begin
        loc_x_d = next_x;
        loc_y_d = next_y;
        moved_d = 1'b1;
      end else begin
        bumped_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      dir_q    <= 4'd0;
      loc_x_q  <= START_XC;
      loc_y_q  <= START_YC;
      moved_q  <= 1'b0;
      bumped_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= bus.dir;
      loc_x_q  <= loc_x_d;
      loc_y_q  <= loc_y_d;
      moved_q  <= moved_d;
      bumped_q <= bumped_d;
    end
  end

  assign bus.loc_x  = loc_x_q;
  assign bus.loc_y  = loc_y_q;
  assign bus.moved  = moved_q;
  assign bus.bumped = bumped_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_maze_icon_mover.sv
// Scoreboard bench for maze_icon_mover with an 8-cycle base step period:
// stimulus pushes expected (edge, moved, bumped, x, y) events, a monitor pops them.
module tb_maze_icon_mover;
  import maze_pkg::*;

  localparam int COORD_W = 8;
  localparam int TICK_W  = 28;
  localparam int PER     = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  maze_icon_mover_if #(.COORD_W(COORD_W)) bus ();
  mover_state_e      state_w;
  logic [TICK_W-1:0] count_w;

  maze_icon_mover #(
    .COORD_W(COORD_W), .MIN_X(3), .MAX_X(124), .MIN_Y(3), .MAX_Y(124),
    .START_X(32), .START_Y(32), .TICK_W(TICK_W), .TICK_PERIOD(PER)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .state_o (state_w),
    .count_o (count_w)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic [33:0] exp_q[$];

  function automatic logic [33:0] ev(input int c, input logic m, input logic b,
                                     input int x, input int y);
    logic [15:0] cc;
    cc = c[15:0];
    return {cc, m, b, x[7:0], y[7:0]};
  endfunction

  task automatic push(input int c, input logic m, input logic b, input int x, input int y);
    exp_q.push_back(ev(c, m, b, x, y));
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: any moved/bumped strobe must match the next queued event exactly,
  // including the edge number it lands on.
  always @(negedge clk) begin
    if (bus.moved || bus.bumped) begin
      logic [33:0] act;
      logic [33:0] e;
      act = {cyc[15:0], bus.moved, bus.bumped, bus.loc_x, bus.loc_y};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL event: unexpected strobe cyc=%0d moved=%0b bumped=%0b x=%0d y=%0d",
                 cyc, bus.moved, bus.bumped, bus.loc_x, bus.loc_y);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL event: got cyc=%0d m=%0b b=%0b x=%0d y=%0d expected cyc=%0d m=%0b b=%0b x=%0d y=%0d",
                   act[33:18], act[17], act[16], act[15:8], act[7:0],
                   e[33:18], e[17], e[16], e[15:8], e[7:0]);
        end
      end
    end
  end

  int c0;
  int mx;
  int my;

  initial begin
    bus.dir    = 4'd0;
    bus.speed  = 2'd0;
    bus.wall_n = 1'b0;
    bus.wall_e = 1'b0;
    bus.wall_s = 1'b0;
    bus.wall_w = 1'b0;
    bus.home   = 1'b0;
    rst_n      = 1'b0;
    wait_n(3);
    check("reset_x", 32'(bus.loc_x), 32);
    check("reset_y", 32'(bus.loc_y), 32);
    check("reset_moved", 32'(bus.moved), 0);
    check("reset_bumped", 32'(bus.bumped), 0);
    check("reset_state", 32'(state_w), 32'(ST_IDLE));
    rst_n = 1'b1;
    wait_n(2);

    // N/S alternation every 5 cycles never reaches an 8-cycle tick
    for (int i = 0; i < 8; i++) begin
      bus.dir = (i % 2 == 0) ? 4'd1 : 4'd2;
      wait_n(5);
    end
    bus.dir = 4'd0;
    wait_n(2);
    check("alt_x", 32'(bus.loc_x), 32);
    check("alt_y", 32'(bus.loc_y), 32);
    check("alt_count", 32'(count_w), 0);

    // North at speed 0: steps 8 and 16 edges after the direction is registered
    c0 = cyc;
    bus.dir = 4'd1;
    push(c0 + 9, 1'b1, 1'b0, 32, 33);
    push(c0 + 17, 1'b1, 1'b0, 32, 34);
    wait_n(3);
    check("run_state", 32'(state_w), 32'(ST_RUN));
    wait_n(14);
    bus.dir = 4'd0;
    wait_n(2);

    // Home from (32,34) moves; home at (32,32) does not
    bus.home = 1'b1;
    push(cyc + 1, 1'b1, 1'b0, 32, 32);
    wait_n(1);
    bus.home = 1'b0;
    check("home_count", 32'(count_w), 0);
    wait_n(2);
    bus.home = 1'b1;
    wait_n(1);
    bus.home = 1'b0;
    check("home_again_moved", 32'(bus.moved), 0);
    check("home_again_x", 32'(bus.loc_x), 32);
    wait_n(2);

    // NE blocked by the east wall, then free after the wall drops
    bus.wall_e = 1'b1;
    c0 = cyc;
    bus.dir = 4'd5;
    push(c0 + 9, 1'b0, 1'b1, 32, 32);
    wait_n(9);
    bus.wall_e = 1'b0;
    push(c0 + 17, 1'b1, 1'b0, 33, 33);
    wait_n(8);
    bus.dir = 4'd0;
    wait_n(2);

    // East at speed 2 (P=2) for 100 steps, running into the X bound
    mx = 33;
    my = 33;
    c0 = cyc;
    bus.dir   = 4'd3;
    bus.speed = 2'd2;
    for (int k = 1; k <= 100; k++) begin
      if (mx < 124) begin
        mx++;
        push(c0 + 1 + 2 * k, 1'b1, 1'b0, mx, my);
      end else begin
`ifdef MAZE_ICON_WRAP_EN
        mx = 3;
        push(c0 + 1 + 2 * k, 1'b1, 1'b0, mx, my);
`else
        push(c0 + 1 + 2 * k, 1'b0, 1'b1, mx, my);
`endif
      end
    end
    wait_n(201);
    bus.dir   = 4'd0;
    bus.speed = 2'd0;
    wait_n(2);

    // West at speed 0; after 5 counts, speed 2 makes the step land on the next edge
    c0 = cyc;
    bus.dir = 4'd4;
    wait_n(6);
    bus.speed = 2'd2;
    push(c0 + 7, 1'b1, 1'b0, mx - 1, my);
    push(c0 + 9, 1'b1, 1'b0, mx - 2, my);
    wait_n(3);
    bus.dir   = 4'd0;
    bus.speed = 2'd0;
    wait_n(2);

    // Asynchronous reset in the middle of a count
    bus.dir = 4'd1;
    wait_n(4);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_x", 32'(bus.loc_x), 32);
    check("async_rst_y", 32'(bus.loc_y), 32);
    check("async_rst_moved", 32'(bus.moved), 0);
    check("async_rst_bumped", 32'(bus.bumped), 0);
    check("async_rst_state", 32'(state_w), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    c0 = cyc;
    push(c0 + 9, 1'b1, 1'b0, 32, 33);
    wait_n(9);
    bus.dir = 4'd0;
    wait_n(3);

    check("queue_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/maze_icon_mover.md
# maze_icon_mover

Parametrised position tracker for the on-screen maze icon. Integrates an 8-direction command from the motor-control path into registered X/Y coordinates at a programmable step rate, with four speed settings, wall-blocking inputs from the maze map lookup, a home/recentre request and per-step status pulses. Sits between the motor-control decoder and the icon/colorizer display logic; its coordinates feed the map lookup that drives its own wall inputs.

## Interface
- COORD_W, 8: coordinate width in bits.
- MIN_X / MAX_X, 3 / 124: inclusive X bounds.
- MIN_Y / MAX_Y, 3 / 124: inclusive Y bounds.
- START_X / START_Y, 32 / 32: reset and home position.
- TICK_W, 28: step-counter width.
- TICK_PERIOD, 1048575: cycles per step at speed 0; must be at least 8.

- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- dir  in  4  direction command: 0 stop, 1 N (Y+1), 2 S (Y−1), 3 E (X+1), 4 W (X−1), 5 NE, 6 SE, 7 SW, 8 NW; 9–15 treated as stop.
- speed  in  2  effective period = TICK_PERIOD >> speed.
- wall_n / wall_e / wall_s / wall_w  in  1 each  move in that direction blocked by the maze wall.
- home  in  1  synchronous recentre request.
- loc_x / loc_y  out  COORD_W each  current position.
- moved  out  1  one-cycle pulse on the edge the position changes.
- bumped  out  1  one-cycle pulse on the edge a step was due but was refused.

## Operation
- Reset: loc_x=START_X, loc_y=START_Y, counter=0, dir_q=0, moved=0, bumped=0.
- States: IDLE (dir_q is stop), RUN (dir_q valid and counting). Every edge registers dir_q<=dir.
- Priority per edge: home > direction change > tick.
- home=1: loads START position, counter<=0, moved=1 if the position changed, bumped=0. Wall and bound checks do not apply.
- dir != dir_q: counter<=0, no step, regardless of state.
- dir == dir_q, RUN: if counter == period−1, counter<=0 and step is attempted; otherwise counter increments. IDLE holds counter at 0.
- Step acceptance: each axis moved must be free (no wall in that direction and not at the bound in that direction). A diagonal step needs both axes free; otherwise neither axis moves (no sliding). Accepted -> moved=1; refused -> bumped=1, position held.
- speed sampled on each tick comparison; a mid-run change applies to the current count and does not restart it; if counter already ≥ new period−1, the step occurs on the next edge.
- Arithmetic: unsigned COORD_W-bit; bounds are checked before add/subtract so no overflow occurs.

## Timing
- Direction registered at edge E0; first step at edge E0+P, where P = TICK_PERIOD >> speed; subsequent steps every P edges.
- Position, moved and bumped update on the same edge; moved/bumped are high for exactly one cycle.
- Wall inputs are sampled combinationally at the step edge. No latency is required from the map lookup beyond setup.
- Reset asserted mid-run: outputs return to reset values immediately (asynchronous). Counting resumes from 0 after release.

## Configuration
- MAZE_ICON_WRAP_EN defined: bounds do not block. Stepping past MAX wraps to MIN and past MIN wraps to MAX on that axis. Walls still block. Diagonal wrap is per axis.
- MAZE_ICON_WRAP_EN undefined: clamp at bounds; the step is refused and bumped pulses.

## Structure
- Shared package maze_pkg: direction codes (DIR_STOP … DIR_NW), the direction-to-delta decode function, and the default bound/start constants.
- Sub-module step_timer: counter, restart-on-change, speed shift and tick pulse. The top level holds direction decode, wall/bound checks and coordinate registers.

## Test plan
- TICK_PERIOD=8, speed=0, dir=1 from reset -> loc_y 32→33 at edge 8 after dir registered, 34 at edge 16; moved pulses each time; loc_x stays 32.
- dir=3, speed=2 (P=2), run 100 steps -> loc_x stops at 124, then bumped pulses every 2 cycles, moved stays 0; in the wrap build loc_x goes 124→3.
- Alternate dir 1/2 every 5 cycles with P=8 -> no step ever, counter restarts; position stays (32,32).
- dir=5 with wall_e=1 at the tick -> no move, bumped=1; with wall_e=0 -> (33,33), moved=1.
- After reaching (40,32), pulse home -> (32,32) next edge, moved=1, counter 0; home at (32,32) -> moved=0.
- Assert rst_n low mid-count at (50,60) -> outputs immediately (32,32), moved=0, bumped=0; after release, the first step is P edges after dir is re-registered.
